// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Sequencing controller for a 5-stage MIPS pipeline. It watches the ID, EX
// and MEM stages and decides, every cycle, whether the front end advances,
// stalls, or is flushed. It also decides whether the whole back end is
// frozen for a slow data-memory access.
//
//   - Load-use hazards cost one stall cycle. The ID instruction is held and
//     a bubble is sent down the pipe.
//   - A taken branch squashes IF and ID. A jump squashes IF.
//   - Multi-cycle memory accesses freeze everything. A wait that outlasts
//     MEM_TIMEOUT cycles parks the controller in ERROR until Reset.
//
// Handshake: there is no valid/ready pair. MemReady acts as the "ready" of
// an access that MEMAccess has made "valid". The access completes in the
// first cycle where both are high. Until then, the pipe holds.
//
// Ports
//   CLK, Reset       rising-edge clock, synchronous active-high reset
//   IDOpcode/IDRs/IDRt/IDJump   decoded fields of the instruction in ID
//   EXMemRead/EXRt/EXBranchTaken  load and branch info from EX
//   MEMAccess, MemReady         data-memory access in MEM and its completion
//   PCWrite, IFIDWrite          front-end load enables
//   IFFlush                     zero IF/ID on the next edge
//   bubble                      zero the pipelined control of the ID instruction
//   PipeHold                    freeze ID/EX, EX/MEM, MEM/WB
//   MemErr                      sticky memory-timeout flag (set while in ERROR)
//   StallCnt                    saturating count of stall cycles
//   dbg_state                   controller state: 0 RUN, 1 MEM_WAIT, 2 ERROR
//
// All outputs are combinational from the current state and the inputs.
// This lets hazards be answered in the same cycle they appear.

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  IDOpcode,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDJump,
  input  logic        EXMemRead,
  input  logic [4:0]  EXRt,
  input  logic        EXBranchTaken,
  input  logic        MEMAccess,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFFlush,
  output logic        bubble,
  output logic        PipeHold,
  output logic        MemErr,
  output logic [15:0] StallCnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic reads_rt;
  logic lu;
  logic eval_hazards;

  // R-type, SW and BEQ consume rt as a source. For every other opcode, rt
  // is a destination or an unused field, so a match on it is not a hazard.
  always_comb begin
    reads_rt = (IDOpcode == 6'b000000) || (IDOpcode == 6'b101011) ||
               (IDOpcode == 6'b000100);
    lu = EXMemRead && (EXRt != 5'd0) &&
         ((EXRt == IDRs) || ((EXRt == IDRt) && reads_rt));
  end

  always_comb begin
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IFFlush      = 1'b0;
    bubble       = 1'b0;
    PipeHold     = 1'b0;
    MemErr       = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    eval_hazards = 1'b0;

    case (state_q)
      S_RUN: begin
        if (MEMAccess && !MemReady) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          PipeHold   = 1'b1;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = 16'd1;
        end else begin
          eval_hazards = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        if (!MemReady) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          PipeHold  = 1'b1;
          // wait_cnt_q counts the hold cycles already completed. This cycle
          // is hold number wait_cnt_q+1. When that number reaches
          // MEM_TIMEOUT, ERROR is entered on the edge that ends this cycle.
          if ((32'(wait_cnt_q) + 32'd1) >= 32'(MEM_TIMEOUT)) begin
            state_d = S_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
        end else begin
          eval_hazards = 1'b1;
          state_d      = S_RUN;
          wait_cnt_d   = 16'd0;
        end
      end

      S_ERROR: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        PipeHold  = 1'b1;
        bubble    = 1'b1;
        MemErr    = 1'b1;
      end

      default: begin
        state_d    = S_RUN;
        wait_cnt_d = 16'd0;
      end
    endcase

    // Front-end hazards. A branch wins over a load-use hazard because the
    // dependent ID instruction is squashed anyway.
    if (eval_hazards) begin
      if (EXBranchTaken) begin
        IFFlush = 1'b1;
        bubble  = 1'b1;
        PCWrite = 1'b1;
      end else if (lu) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        bubble    = 1'b1;
      end else if (IDJump) begin
        IFFlush = 1'b1;
        PCWrite = 1'b1;
      end
    end

    if (!PCWrite && (state_q != S_ERROR) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Reset overrides everything. The pipe is flushed and bubbled so that no
    // output of an aborted state survives past the reset cycle.
    if (Reset) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IFFlush     = 1'b1;
      bubble      = 1'b1;
      PipeHold    = 1'b0;
      MemErr      = 1'b0;
      state_d     = S_RUN;
      wait_cnt_d  = 16'd0;
      stall_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt  = stall_cnt_q;
  assign dbg_state = state_q;

endmodule
